// File: rtl/harris_cim_pkg.sv
// Shared types and constants for the Harris cim sequencer.
// Used by harris_cim_sched and harris_cim_mac.
package harris_cim_pkg;

   localparam int CIM_IN_SHIFT = 6;
   localparam int CIM_SS_SHIFT = 4;

   typedef enum logic [2:0] {
      IDLE,
      AB,
      CC,
      SS,
      DONE
   } cim_state_t;

   typedef enum logic [1:0] {
      STEP_NONE,
      STEP_AB,
      STEP_CC,
      STEP_SS
   } cim_step_t;

endpackage

// File: rtl/harris_cim_mac.sv
// Single shared multiplier with operand mux and accumulate/subtract.
// The step select picks operands and the accumulator update.
module harris_cim_mac
   import harris_cim_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  cim_step_t    step_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] c_i,
   input  logic [W-1:0] s_i,
   output logic [W-1:0] acc_d_o
);

   logic [W-1:0] op_x;
   logic [W-1:0] op_y;
   logic [W-1:0] prod;
   logic [W-1:0] ss_term;
   logic [W-1:0] acc_q;
   logic [W-1:0] acc_d;

   // Operand mux feeding the one multiplier
   always_comb begin
      op_x = a_i;
      op_y = b_i;
      case (step_i)
         STEP_CC: begin
            op_x = c_i;
            op_y = c_i;
         end
         STEP_SS: begin
            op_x = s_i;
            op_y = s_i;
         end
         default: begin
            op_x = a_i;
            op_y = b_i;
         end
      endcase
   end

   assign prod    = op_x * op_y;
   assign ss_term = $signed(prod) >>> CIM_SS_SHIFT;

   // Accumulator next value for the current step
   always_comb begin
      acc_d = acc_q;
      case (step_i)
         STEP_AB: acc_d = prod;
         STEP_CC: acc_d = acc_q - prod;
         STEP_SS: acc_d = acc_q - ss_term;
         default: acc_d = acc_q;
      endcase
   end

   // Accumulator register
   always_ff @(posedge clk) begin
      if (!rst_n) acc_q <= '0;
      else        acc_q <= acc_d;
   end

   assign acc_d_o = acc_d;

endmodule

// File: rtl/harris_cim_sched.sv
// Harris cim sequencer: FSM, handshake and operand registers.
// Optional threshold output enabled by HARRIS_CIM_THRESH_EN.
module harris_cim_sched
   import harris_cim_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_lgxx,
   input  logic [W-1:0] in_lgxy,
   input  logic [W-1:0] in_lgyy,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_cim,
   output logic         busy
`ifdef HARRIS_CIM_THRESH_EN
   ,
   input  logic [W-1:0] thresh,
   output logic         out_corner
`endif
);

   cim_state_t   state_q;
   logic         vld_q;
   logic [W-1:0] cim_q;
   logic [W-1:0] a_q, b_q, c_q, s_q;
   logic [W-1:0] a_d, b_d, c_d, s_d;
   logic [W-1:0] acc_d;
   logic         accept;
   cim_step_t    step;

   assign in_ready = (state_q == IDLE) ||
                     (state_q == DONE && out_ready);
   assign accept   = in_valid && in_ready;
   assign busy     = (state_q != IDLE);

   assign a_d = $signed(in_lgxx) >>> CIM_IN_SHIFT;
   assign b_d = $signed(in_lgyy) >>> CIM_IN_SHIFT;
   assign c_d = $signed(in_lgxy) >>> CIM_IN_SHIFT;
   assign s_d = a_d + b_d;

   // Multiplier step follows the FSM state
   always_comb begin
      step = STEP_NONE;
      case (state_q)
         AB:      step = STEP_AB;
         CC:      step = STEP_CC;
         SS:      step = STEP_SS;
         default: step = STEP_NONE;
      endcase
   end

   harris_cim_mac #(.W(W)) u_mac (
      .clk     (clk),
      .rst_n   (rst_n),
      .step_i  (step),
      .a_i     (a_q),
      .b_i     (b_q),
      .c_i     (c_q),
      .s_i     (s_q),
      .acc_d_o (acc_d)
   );

`ifdef HARRIS_CIM_THRESH_EN
   logic corner_q;

   // Corner flag captured alongside the final result
   always_ff @(posedge clk) begin
      if (!rst_n)
         corner_q <= 1'b0;
      else if (state_q == SS)
         corner_q <= $signed(acc_d) > $signed(thresh);
   end

   assign out_corner = corner_q;
`endif

   // Sequencer FSM with registered result outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vld_q   <= 1'b0;
         cim_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         s_q     <= '0;
      end else begin
         if (accept) begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
            s_q <= s_d;
         end
         case (state_q)
            IDLE: if (accept) state_q <= AB;
            AB:   state_q <= CC;
            CC:   state_q <= SS;
            SS: begin
               state_q <= DONE;
               vld_q   <= 1'b1;
               cim_q   <= acc_d;
            end
            DONE: begin
               if (out_ready) begin
                  vld_q   <= 1'b0;
                  state_q <= in_valid ? AB : IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               vld_q   <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = vld_q;
   assign out_cim   = cim_q;

endmodule

// File: tb/tb_harris_cim_sched.sv
// Self-checking bench for harris_cim_sched.
// Reference model plus directed vectors with literal results.
module tb_harris_cim_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_lgxx, in_lgxy, in_lgyy;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_cim;
   logic        busy;
   logic [15:0] thresh;
`ifdef HARRIS_CIM_THRESH_EN
   logic        out_corner;
`endif

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   harris_cim_sched #(.W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_lgxx   (in_lgxx),
      .in_lgxy   (in_lgxy),
      .in_lgyy   (in_lgyy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_cim   (out_cim),
      .busy      (busy)
`ifdef HARRIS_CIM_THRESH_EN
      ,
      .thresh    (thresh),
      .out_corner(out_corner)
`endif
   );

   function automatic int fdiv(input int x, input int d);
      int q;
      q = x / d;
      if ((x % d != 0) && (x < 0)) q = q - 1;
      return q;
   endfunction

   function automatic int sx16(input int x);
      logic [15:0] t;
      t = x[15:0];
      return int'($signed(t));
   endfunction

   // cim from the arithmetic definition, wrapped to 16 bits
   function automatic logic [15:0] cim_ref(input logic [15:0] xx,
                                           input logic [15:0] xy,
                                           input logic [15:0] yy);
      int a, b, c, s, term, r;
      a    = fdiv(int'($signed(xx)), 64);
      b    = fdiv(int'($signed(yy)), 64);
      c    = fdiv(int'($signed(xy)), 64);
      s    = sx16(a + b);
      term = fdiv(sx16(s * s), 16);
      r    = a * b - c * c - term;
      return r[15:0];
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Transaction-level model: result appears 3 edges after accept
   int          m_cnt = 0;
   bit          m_valid = 0;
   logic [15:0] m_cim = 0, m_next = 0;
   bit          m_corner = 0, m_next_corner = 0;
   logic        m_rdy, m_acc, m_busy;

   assign m_rdy  = (m_cnt == 0 && !m_valid) || (m_valid && out_ready);
   assign m_acc  = in_valid && m_rdy;
   assign m_busy = m_valid || (m_cnt != 0);

   always @(posedge clk) begin
      if (!rst_n) begin
         m_cnt    <= 0;
         m_valid  <= 1'b0;
         m_cim    <= '0;
         m_corner <= 1'b0;
      end else begin
         if (m_acc) begin
            m_cnt         <= 3;
            m_next        <= cim_ref(in_lgxx, in_lgxy, in_lgyy);
            m_next_corner <= $signed(cim_ref(in_lgxx, in_lgxy, in_lgyy))
                             > $signed(thresh);
         end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
         end
         if (m_cnt == 1) begin
            m_valid  <= 1'b1;
            m_cim    <= m_next;
            m_corner <= m_next_corner;
         end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid", out_valid, m_valid);
         check("in_ready", in_ready, m_rdy);
         check("busy", busy, m_busy);
         if (m_valid) begin
            check("out_cim", out_cim, m_cim);
`ifdef HARRIS_CIM_THRESH_EN
            check("out_corner", out_corner, m_corner);
`endif
         end
      end
   end

   task automatic send(input logic [15:0] xx, input logic [15:0] xy,
                       input logic [15:0] yy, input string nm);
      int n;
      n = 0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_lgxx  = xx;
      in_lgxy  = xy;
      in_lgyy  = yy;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check({nm, "_accept_timeout"}, n, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Waits from just after the accept edge; returns extra cycles seen
   task automatic wait_valid(input string nm, output int n);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 12) begin
         @(negedge clk);
         n++;
      end
      if (n >= 12) check({nm, "_valid_timeout"}, n, 3);
   endtask

   task automatic run_lit(input logic [15:0] xx, input logic [15:0] xy,
                          input logic [15:0] yy, input logic [15:0] exp,
                          input string nm);
      int n;
      send(xx, xy, yy, nm);
      wait_valid(nm, n);
      check({nm, "_latency"}, n, 3);
      check({nm, "_cim"}, out_cim, exp);
   endtask

   initial begin
      int          n;
      logic [15:0] held;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_lgxx   = '0;
      in_lgxy   = '0;
      in_lgyy   = '0;
      out_ready = 1'b1;
      thresh    = 16'd50;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_cim", out_cim, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);
`ifdef HARRIS_CIM_THRESH_EN
      check("rst_out_corner", out_corner, 0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_lit(16'd640, 16'd0, 16'd640, 16'h004B, "basic");
      run_lit(16'd192, 16'd64, 16'd128, 16'h0004, "small");
      run_lit(16'hFD80, 16'd0, 16'd640, 16'hFF9C, "negative");
      run_lit(16'h7FC0, 16'd0, 16'h7FC0, 16'hFD01, "wrap");

      send(16'hFFFF, 16'hFFFF, 16'hFFFF, "allones");
      wait_valid("allones", n);
      send(16'h8000, 16'h8000, 16'h7FFF, "extreme");
      wait_valid("extreme", n);
      send(16'h1234, 16'hF00D, 16'h0ABC, "mixed");
      wait_valid("mixed", n);

      // Backpressure in DONE, then release with a new triple
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(16'd192, 16'd64, 16'd128, "bp");
      wait_valid("bp", n);
      held = out_cim;
      check("bp_cim", out_cim, 16'h0004);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_stable", out_cim, held);
         check("bp_in_ready", in_ready, 0);
         check("bp_out_valid", out_valid, 1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_lgxx   = 16'd640;
      in_lgxy   = 16'd0;
      in_lgyy   = 16'd640;
      @(negedge clk);
      check("bp_release_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid("bp2", n);
      check("bp2_latency", n, 3);
      check("bp2_cim", out_cim, 16'h004B);

      // Reset while in SS discards the in-flight result
      send(16'd640, 16'd0, 16'd640, "rst");
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", in_ready, 1);
      check("mid_rst_cim", out_cim, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("no_stale", out_valid, 0);
      end

      run_lit(16'hFD80, 16'd0, 16'd640, 16'hFF9C, "after_rst");

      @(posedge clk); #1;
      @(posedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
